wb_stage_writer: RTL
====================

// Module: wb_stage_writer
// PURPOSE
//  MEM/WB pipeline register plus writeback mux. Sole driver of the RegisterFile
//  write port (write, writeData, RegWrite) in the pipelined CPU. Captures MEM
//  results, selects ALU result or load data, suppresses writes to $0, and
//  counts retired instructions. Sits between the MEM stage and RegisterFile.
// PARAMETERS
//  DATA_W   32  datapath width (writeData, ALU result, load data, counter)
//  ADDR_W   5   register index width (32 GPRs)
// PORTS
//  CLK          in   1       clock; all state updates on posedge
//  RST_N        in   1       synchronous active-low reset
//  stall        in   1       hold MEM/WB contents this edge
//  flush        in   1       invalidate MEM/WB contents this edge
//  in_valid     in   1       MEM stage holds a real instruction
//  in_RegWrite  in   1       instruction writes a GPR
//  in_MemtoReg  in   1       1: writeData = load data; 0: ALU result
//  in_write     in   ADDR_W  destination register index
//  in_aluResult in   DATA_W  ALU result from MEM stage
//  in_readData  in   DATA_W  data-memory load data
//  RegWrite     out  1       RegisterFile write enable
//  write        out  ADDR_W  RegisterFile write index
//  writeData    out  DATA_W  RegisterFile write data
//  retired      out  DATA_W  retired-instruction count
//  (WB_BYPASS_EN only) read1, read2 in ADDR_W; register1_in, register2_in in
//  DATA_W; register1_fwd, register2_fwd out DATA_W
// BEHAVIOUR
//  - One clock (CLK); reset synchronous, active-low (RST_N).
//  - Reset edge: valid_q=0, RegWrite_q=0, MemtoReg_q=0, write_q=0, data regs=0,
//    retired=0. Hence RegWrite=0, write=0, writeData=0 out of reset.
//  - Edge priority: reset > flush > stall > capture.
//    flush: valid_q<=0, other regs don't-care (held). stall: all regs hold.
//    capture: all in_* registered.
//  - Output (combinational from regs): RegWrite = valid_q & RegWrite_q &
//    (write_q != 0); write = write_q; writeData = MemtoReg_q ? readData_q :
//    aluResult_q. Both data inputs registered; mux after the register.
//  - Latency: inputs at edge N appear on the write port during cycle N..N+1;
//    RegisterFile commits at edge N+1.
//  - Stall with valid_q: RegWrite stays asserted; repeated identical write
//    is idempotent, allowed.
//  - retired increments by 1 at each non-reset edge where valid_q=1 and
//    (flush | ~stall): each instruction counted exactly once, including
//    $0-destination and non-writing ones. Wraps 2^DATA_W-1 -> 0, no flag.
//  - Reset mid-stall or mid-flush: reset wins; no retire count that edge.
// CONFIGURATION
//  - WB_BYPASS_EN defined: bypass ports present. registerN_fwd = (RegWrite &
//    write==readN) ? writeData : registerN_in, purely combinational; fixes
//    same-cycle write/read hazard in decode. readN==0 never forwards (RegWrite
//    already 0 for $0).
//  - WB_BYPASS_EN undefined: bypass ports absent; decode sees RegisterFile
//    output only; the hazard unit covers the gap.
// STRUCTURE
//  - Shared package cpu_pkg: DATA_W/ADDR_W constants, REG_ZERO=5'd0,
//    MEMTOREG_ALU=1'b0 / MEMTOREG_MEM=1'b1 encodings.
//  - One sub-module natural: wb_bypass_mux (one read port's compare+select),
//    instanced twice under WB_BYPASS_EN. Pipeline reg and counter stay inline.
// TESTING
//  1 RST_N=0 two edges, then release -> RegWrite=0, write=0, writeData=0,
//    retired=0.
//  2 Capture valid,RegWrite=1,MemtoReg=0,write=3,alu=0x11,readData=0x22 ->
//    next cycle RegWrite=1, write=3, writeData=0x11; RegisterFile reg3=0x11
//    after following edge; retired=1.
//  3 Same with write=0 -> RegWrite=0, retired still increments; MemtoReg=1,
//    write=4 -> writeData=0x22.
//  4 Hold stall=1 for 3 edges with valid_q -> outputs constant, retired
//    unchanged; release -> retired+1. stall=1 & flush=1 -> valid_q=0, +1.
//  5 Preload retired=0xFFFFFFFF (force), retire one -> 0x00000000.
//  6 WB_BYPASS_EN: write=5 data=0xAB, read1=5, register1_in=0x00 ->
//    register1_fwd=0xAB; read2=6 -> register2_fwd=register2_in.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, register-zero index and writeback
// source encodings used by the MEM/WB stage.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam logic MEMTOREG_ALU = 1'b0;
    localparam logic MEMTOREG_MEM = 1'b1;

    typedef enum logic {
        WB_SRC_ALU = MEMTOREG_ALU,
        WB_SRC_MEM = MEMTOREG_MEM
    } wb_src_e;

    function automatic wb_src_e wb_src(input logic mem_to_reg);
        return (mem_to_reg == MEMTOREG_MEM) ? WB_SRC_MEM : WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// One decode read port's writeback bypass: forward the in-flight write data
// when the RegisterFile is being written to the register being read.
`ifdef WB_BYPASS_EN
module wb_bypass_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_idx,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_idx,
    input  logic [DATA_W-1:0] reg_in,
    output logic [DATA_W-1:0] reg_fwd
);

    logic hit;

    // reg_write is already low for $0, so reads of $0 never forward
    assign hit     = reg_write && (write_idx == read_idx);
    assign reg_fwd = hit ? write_data : reg_in;

endmodule
`endif

// File: rtl/wb_stage_writer.sv
// MEM/WB pipeline register, writeback mux and retired-instruction counter.
// Define WB_BYPASS_EN to add the same-cycle write/read bypass ports.
module wb_stage_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    input  logic [ADDR_W-1:0] in_write,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_readData,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    input  logic [DATA_W-1:0] register1_in,
    input  logic [DATA_W-1:0] register2_in,
    output logic [DATA_W-1:0] register1_fwd,
    output logic [DATA_W-1:0] register2_fwd,
`endif
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write,
    output logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] retired
);

    import cpu_pkg::*;

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic [ADDR_W-1:0] write_q, write_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] retired_q, retired_d;
    logic              retire;

    // An occupied slot leaves the stage when it is flushed or not held
    assign retire = valid_q && (flush || !stall);

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        write_d      = write_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        retired_d    = retired_q;
        if (retire) begin
            retired_d = retired_q + DATA_W'(1);
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d      = in_valid;
            reg_write_d  = in_RegWrite;
            mem_to_reg_d = in_MemtoReg;
            write_d      = in_write;
            alu_result_d = in_aluResult;
            read_data_d  = in_readData;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= MEMTOREG_ALU;
            write_q      <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            write_q      <= write_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            retired_q    <= retired_d;
        end
    end

    assign RegWrite  = valid_q && reg_write_q
                     && (write_q != ADDR_W'(REG_ZERO));
    assign write     = write_q;
    assign writeData = (wb_src(mem_to_reg_q) == WB_SRC_MEM)
                     ? read_data_q : alu_result_q;
    assign retired   = retired_q;

`ifdef WB_BYPASS_EN
    wb_bypass_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_bypass1 (
        .reg_write (RegWrite),
        .write_idx (write),
        .write_data(writeData),
        .read_idx  (read1),
        .reg_in    (register1_in),
        .reg_fwd   (register1_fwd)
    );

    wb_bypass_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_bypass2 (
        .reg_write (RegWrite),
        .write_idx (write),
        .write_data(writeData),
        .read_idx  (read2),
        .reg_in    (register2_in),
        .reg_fwd   (register2_fwd)
    );
`endif

endmodule
